// File: rtl/eth_led_pkg.sv
// Shared definitions for the Ethernet PHY LED status controller.
//   port_state_t : per-port LED state machine encoding
//   LM_*         : led_mode values (normal / all off / lamp test / locate)
package eth_led_pkg;

  typedef enum logic [1:0] {
    DOWN    = 2'd0,
    UP_IDLE = 2'd1,
    UP_ACT  = 2'd2
  } port_state_t;

  localparam logic [1:0] LM_NORMAL = 2'd0;
  localparam logic [1:0] LM_OFF    = 2'd1;
  localparam logic [1:0] LM_LAMP   = 2'd2;
  localparam logic [1:0] LM_LOCATE = 2'd3;

endpackage

// File: rtl/eth_led_port.sv
// One PHY port's LED status path: 2-flop input synchronizers, link debounce,
// activity pulse stretching, DOWN/UP_IDLE/UP_ACT state machine and the
// registered LED output mux with global mode override.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   phy_link/spd100/act       raw PHY signals (asynchronous to clk)
//   led_mode                  global LED mode (clk domain)
//   blink_phase, blink_wrap   shared blink generator phase and wrap strobe
//   led_link/speed/act        registered LED drives
//   link_chg                  1-cycle pulse per accepted link transition
module eth_led_port
  import eth_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned STRETCH_CYC  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_link,
  input  logic       phy_spd100,
  input  logic       phy_act,
  input  logic [1:0] led_mode,
  input  logic       blink_phase,
  input  logic       blink_wrap,
  output logic       led_link,
  output logic       led_speed,
  output logic       led_act,
  output logic       link_chg
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned ST_W = $clog2(STRETCH_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYC);

  logic [1:0]      link_sync, spd_sync, act_sync;
  logic            link_s, spd_s, act_s, act_d, act_rise;
  logic            link_db, link_db_nxt, accept, chg_q;
  logic [DB_W-1:0] db_cnt;
  logic [ST_W-1:0] st_cnt;
  logic            act_hot;
  port_state_t     state_q, state_d;

  assign link_s   = link_sync[1];
  assign spd_s    = spd_sync[1];
  assign act_s    = act_sync[1];
  assign act_rise = act_s & ~act_d;
  assign act_hot  = (st_cnt != '0);

  assign accept      = (link_s != link_db) && (db_cnt == DB_LAST);
  assign link_db_nxt = accept ? link_s : link_db;

  // Synchronizers, debounce and stretch.
  // link_chg is pipelined one stage so it lines up with the LED outputs,
  // which are registered from the state that moves together with link_db.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_sync <= '0;
      spd_sync  <= '0;
      act_sync  <= '0;
      act_d     <= 1'b0;
      link_db   <= 1'b0;
      db_cnt    <= '0;
      chg_q     <= 1'b0;
      link_chg  <= 1'b0;
      st_cnt    <= '0;
    end else begin
      link_sync <= {link_sync[0], phy_link};
      spd_sync  <= {spd_sync[0], phy_spd100};
      act_sync  <= {act_sync[0], phy_act};
      act_d     <= act_s;

      if (link_s == link_db || accept) db_cnt <= '0;
      else                             db_cnt <= db_cnt + DB_W'(1);
      link_db  <= link_db_nxt;
      chg_q    <= accept;
      link_chg <= chg_q;

      if (!link_db)          st_cnt <= '0;
      else if (act_rise)     st_cnt <= ST_LOAD;
      else if (st_cnt != '0) st_cnt <= st_cnt - ST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DOWN;
    else      state_q <= state_d;
  end

  // The FSM follows the debounced link on the same edge link_db updates,
  // so the LEDs go dark one cycle after link_db falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DOWN:    if (link_db_nxt) state_d = UP_IDLE;
      UP_IDLE: if (act_hot) state_d = UP_ACT;
      UP_ACT:  if (!act_hot && blink_wrap && blink_phase) state_d = UP_IDLE;
      default: state_d = DOWN;
    endcase
    if (!link_db_nxt) state_d = DOWN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_link  <= 1'b0;
      led_speed <= 1'b0;
      led_act   <= 1'b0;
    end else begin
      case (led_mode)
        LM_OFF: begin
          led_link  <= 1'b0;
          led_speed <= 1'b0;
          led_act   <= 1'b0;
        end
        LM_LAMP: begin
          led_link  <= 1'b1;
          led_speed <= 1'b1;
          led_act   <= 1'b1;
        end
        LM_LOCATE: begin
          led_link  <= blink_phase;
          led_speed <= blink_phase;
          led_act   <= blink_phase;
        end
        default: begin
          led_link  <= (state_q != DOWN);
          led_speed <= (state_q != DOWN) & spd_s;
          led_act   <= (state_q == UP_IDLE) | ((state_q == UP_ACT) & ~blink_phase);
        end
      endcase
    end
  end

endmodule

// File: rtl/eth_led_status_ctrl.sv
// Multi-port Ethernet PHY LED status controller top level.
// Holds the shared blink generator and instantiates one eth_led_port per PHY.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   phy_link/phy_spd100/phy_act     raw per-port PHY signals (asynchronous)
//   led_mode                        0 normal, 1 all off, 2 lamp test, 3 locate
//   led_link/led_speed/led_act      per-port LED drives
//   link_chg                        per-port debounced link change pulse
module eth_led_status_ctrl
  import eth_led_pkg::*;
#(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter int unsigned STRETCH_CYC    = 2500000,
  parameter int unsigned BLINK_HALF_CYC = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] phy_link,
  input  logic [N_PORTS-1:0] phy_spd100,
  input  logic [N_PORTS-1:0] phy_act,
  input  logic [1:0]         led_mode,
  output logic [N_PORTS-1:0] led_link,
  output logic [N_PORTS-1:0] led_speed,
  output logic [N_PORTS-1:0] led_act,
  output logic [N_PORTS-1:0] link_chg
);

  localparam int unsigned BL_W = $clog2(BLINK_HALF_CYC + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYC - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            blink_wrap;

  assign blink_wrap = (blink_cnt == BL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + BL_W'(1);
      blink_phase <= blink_phase ^ blink_wrap;
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    eth_led_port #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .STRETCH_CYC (STRETCH_CYC)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .phy_link   (phy_link[g]),
      .phy_spd100 (phy_spd100[g]),
      .phy_act    (phy_act[g]),
      .led_mode   (led_mode),
      .blink_phase(blink_phase),
      .blink_wrap (blink_wrap),
      .led_link   (led_link[g]),
      .led_speed  (led_speed[g]),
      .led_act    (led_act[g]),
      .link_chg   (link_chg[g])
    );
  end

endmodule
